// File: rtl/shift_issue_queue.sv
// shift_issue_queue: a DEPTH-entry request FIFO that feeds an external
// combinational barrel shifter, plus a result register with its own
// valid/ready handshake toward writeback.
// Optional build macro SHIFT_ISSUE_STATS_EN adds saturating completion and
// stall counters (stat_done, stat_stall).
module shift_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [4:0]  in_b,
  input  logic [1:0]  in_aluc,
  output logic [31:0] sh_a,
  output logic [4:0]  sh_b,
  output logic [1:0]  sh_aluc,
  input  logic [31:0] sh_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_c
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  output logic [15:0] stat_done,
  output logic [15:0] stat_stall
`endif
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  // Entry storage; validity is tracked by count_q, so no per-entry reset.
  logic [31:0] mem_a_q    [DEPTH];
  logic [4:0]  mem_b_q    [DEPTH];
  logic [1:0]  mem_aluc_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_c_q, out_c_d;

  logic head_valid;
  logic slot_free;
  logic push;
  logic pop;

  // Handshake qualifiers; in_ready depends only on registered count.
  always_comb begin
    head_valid = (count_q != '0);
    in_ready   = (count_q != CNT_FULL);
    slot_free  = !out_valid_q || out_ready;
    push       = in_valid && in_ready && !flush;
    pop        = head_valid && slot_free && !flush;
  end

  // Head entry onto the shifter bus; zeros when the queue is empty.
  always_comb begin
    sh_a    = '0;
    sh_b    = '0;
    sh_aluc = '0;
    if (head_valid) begin
      sh_a    = mem_a_q[rd_ptr_q];
      sh_b    = mem_b_q[rd_ptr_q];
      sh_aluc = mem_aluc_q[rd_ptr_q];
    end
  end

  // Entry write on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]    <= in_a;
      mem_b_q[wr_ptr_q]    <= in_b;
      mem_aluc_q[wr_ptr_q] <= in_aluc;
    end
  end

  // Next-state for pointers, occupancy and result register; flush wins.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        out_valid_d = 1'b1;
        out_c_d     = sh_c;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and result state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;

`ifdef SHIFT_ISSUE_STATS_EN
  logic [15:0] stat_done_q, stat_done_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  // Saturating event counters, cleared by flush.
  always_comb begin
    stat_done_d  = stat_done_q;
    stat_stall_d = stat_stall_q;
    if (flush) begin
      stat_done_d  = '0;
      stat_stall_d = '0;
    end else begin
      if (out_valid_q && out_ready && (stat_done_q != 16'hFFFF))
        stat_done_d = stat_done_q + 16'd1;
      if (in_valid && !in_ready && (stat_stall_q != 16'hFFFF))
        stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_done_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_done_q  <= stat_done_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_done  = stat_done_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_shift_issue_queue.sv
// Scoreboard bench for shift_issue_queue with a behavioural barrel shifter
// closing the sh_* -> sh_c loop.
module tb_shift_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [4:0]  in_b;
  logic [1:0]  in_aluc;
  logic [31:0] sh_a;
  logic [4:0]  sh_b;
  logic [1:0]  sh_aluc;
  logic [31:0] sh_c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_c;
`ifdef SHIFT_ISSUE_STATS_EN
  logic [15:0] stat_done;
  logic [15:0] stat_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  shift_issue_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_aluc   (in_aluc),
    .sh_a      (sh_a),
    .sh_b      (sh_b),
    .sh_aluc   (sh_aluc),
    .sh_c      (sh_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c)
`ifdef SHIFT_ISSUE_STATS_EN
    ,
    .stat_done (stat_done),
    .stat_stall(stat_stall)
`endif
  );

  // Behavioural 32-bit barrel shifter: 00 SRA, 01 SRL, 1x SLL.
  always_comb begin
    case (sh_aluc)
      2'b00:   sh_c = $unsigned($signed(sh_a) >>> sh_b);
      2'b01:   sh_c = sh_a >> sh_b;
      default: sh_c = sh_a << sh_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
      $display("check %-22s act=%08h req=%08h ok", name, act, req);
    end else begin
      $display("FAIL %-22s act=%08h req=%08h", name, act, req);
    end
  endtask

  // Monitor: every result handshake pops the oldest expected value.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", out_c, 32'hDEADDEAD);
        end else begin
          check("result_order", out_c, sb.pop_front());
        end
      end
    end
  endtask

  // Offer one request for up to budget cycles; record expected on accept.
  task automatic push_req(input logic [31:0] a, input logic [4:0] b, input logic [1:0] op,
                          input logic [31:0] exp_c, input int budget, output bit acc);
    in_a = a; in_b = b; in_aluc = op; in_valid = 1'b1; acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      if (in_ready) begin
        acc = 1'b1;
        sb.push_back(exp_c);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check(name, 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] t3_exp [6];
  logic [31:0] t4_exp [8];
  bit acc;

  initial begin
    t3_exp = '{32'h2, 32'h4, 32'h8, 32'h10, 32'h20, 32'h40};
    t4_exp = '{32'h40000000, 32'h20000000, 32'h10000000, 32'h08000000,
               32'h04000000, 32'h02000000, 32'h01000000, 32'h00800000};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_aluc = '0;
    fork
      monitor_loop();
    join_none
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_c", out_c, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sh_a", sh_a, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single op latency and one-cycle valid
    out_ready = 1'b1;
    push_req(32'hFEEE1234, 5'd10, 2'b10, 32'hB848D000, 1, acc);
    check("s1_valid_after_t", 32'(out_valid), 32'd0);
    check("s1_sh_a_head", sh_a, 32'hFEEE1234);
    @(posedge clk); #1;
    check("s1_valid_after_t1", 32'(out_valid), 32'd1);
    check("s1_out_c", out_c, 32'hB848D000);
    @(posedge clk); #1;
    check("s1_valid_cleared", 32'(out_valid), 32'd0);
    check("s1_sh_a_empty", sh_a, 32'd0);

    // 2: mixed ops back-to-back
    push_req(32'hE10381AB, 5'd2,  2'b01, 32'h3840E06A, 1, acc);
    push_req(32'h80000000, 5'd4,  2'b00, 32'hF8000000, 1, acc);
    push_req(32'h00000001, 5'd31, 2'b11, 32'h80000000, 1, acc);
    drain("s2_drained");

    // 3: backpressure, 4 queued + 1 held in out_c
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push_req(32'h1, 5'(k + 1), 2'b10, t3_exp[k], 2, acc);
      check("s3_accept", 32'(acc), 32'd1);
    end
    check("s3_in_ready_full", 32'(in_ready), 32'd0);
    push_req(32'h1, 5'd6, 2'b10, t3_exp[5], 3, acc);
    check("s3_sixth_blocked", 32'(acc), 32'd0);
`ifdef SHIFT_ISSUE_STATS_EN
    check("s3_stat_stall", 32'(stat_stall), 32'd3);
`endif
    out_ready = 1'b1;
    push_req(32'h1, 5'd6, 2'b10, t3_exp[5], 6, acc);
    check("s3_sixth_accept", 32'(acc), 32'd1);
    drain("s3_drained");

    // 4: fill, then consume while pushing more
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_req(32'h80000000, 5'(k + 1), 2'b01, t4_exp[k], 2, acc);
    check("s4_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int k = 5; k < 8; k++) begin
      push_req(32'h80000000, 5'(k + 1), 2'b01, t4_exp[k], 4, acc);
      check("s4_accept", 32'(acc), 32'd1);
    end
    drain("s4_drained");

    // 5: flush with 3 queued and a held result
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_req(32'h1, 5'(k), 2'b10, 32'h0, 2, acc);
    check("s5_valid_before", 32'(out_valid), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    check("s5_valid_flushed", 32'(out_valid), 32'd0);
    check("s5_in_ready", 32'(in_ready), 32'd1);
    check("s5_sh_a_empty", sh_a, 32'd0);
`ifdef SHIFT_ISSUE_STATS_EN
    check("s5_stat_stall_clr", 32'(stat_stall), 32'd0);
`endif
    out_ready = 1'b1;
    push_req(32'h0000000F, 5'd4, 2'b10, 32'h000000F0, 1, acc);
    drain("s5_drained");
    repeat (2) @(posedge clk); #1;
    check("s5_no_extra", 32'(out_valid), 32'd0);

    // 6: asynchronous reset mid-stream
    out_ready = 1'b0;
    push_req(32'h12345678, 5'd8, 2'b10, 32'h0, 1, acc);
    push_req(32'h12345678, 5'd4, 2'b01, 32'h0, 1, acc);
    check("s6_valid_before", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("s6_rst_valid", 32'(out_valid), 32'd0);
    check("s6_rst_out_c", out_c, 32'd0);
    check("s6_rst_in_ready", 32'(in_ready), 32'd1);
    check("s6_rst_sh_a", sh_a, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    push_req(32'h00000003, 5'd1, 2'b10, 32'h00000006, 1, acc);
    drain("s6_post_drained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
